m_unit_controller: RTL and testbench
====================================

# m_unit_controller

Sequencing controller for the RISC-V M-extension unit. It decodes an incoming MUL/DIV/REM instruction, drives the operand-load, multiply-enable and divide-step strobes into the datapath, and counts iterative cycles. It handles the divide-by-zero and signed-overflow corner cases and selects the final result through the datapath output mux. It sits between the core's request handshake (valid/busy/ready/wr) and the M-unit register file and ALU.

## Interface
Parameters:
- MUL_CYCLES, 2, cycles spent in the multiply state (≥1)
- DIV_CYCLES, 32, restoring-division steps per divide (≥1)

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- valid  in  1  request strobe from the core
- instruction  in  32  instruction word, sampled with valid
- rs1_msb  in  1  sign bit of rs1
- rs2_msb  in  1  sign bit of rs2
- rs2_zero  in  1  rs2 == 0
- div_ovf  in  1  rs1 == 0x80000000 and rs2 == 0xFFFFFFFF
- load  out  1  datapath captures rs1/rs2 at the end of this cycle
- mul_en  out  1  multiplier active
- mul_signed_a  out  1  treat rs1 as signed
- mul_signed_b  out  1  treat rs2 as signed
- div_step  out  1  ALU performs one division step
- mux_out  out  MUX_OUT_LENGTH (3)  result select
- busy  out  1  request in flight
- ready  out  1  one-cycle pulse, result valid on rd
- wr  out  1  write-back enable, coincident with ready

## Operation
- Decode: opcode 0110011 with funct7 0000001 is an M instruction. funct3 selects the operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Any other instruction is ignored: the controller stays in IDLE and ready is never pulsed.
- States:
  - IDLE → MUL on valid & multiply.
  - IDLE → DIV on valid & divide & !special.
  - IDLE → DONE on valid & divide & special.
  - MUL → DONE after MUL_CYCLES cycles.
  - DIV → DONE after DIV_CYCLES cycles.
  - DONE → IDLE unconditionally.
- load = valid & M-decode in IDLE, combinational from those inputs.
- Latched on acceptance: funct3, signs, and the special-case flags (rs2_zero, div_ovf, and only for signed ops).
- Multiply:
  - mul_en is high throughout MUL.
  - mul_signed_a = MULH | MULHSU; mul_signed_b = MULH.
- Divide: div_step is high every DIV cycle. The cycle counter runs from 0 to DIV_CYCLES-1.
- Result select in DONE:
  - MUL → MULT_LOWER; MULH/MULHSU/MULHU → MULT_UPPER.
  - DIV, signs differ → DIV_REM_NEG; DIV otherwise, and DIVU → DIV_REM.
  - REM with rs1 negative → DIV_REM_NEG; REM otherwise, and REMU → DIV_REM.
  - DIV/DIVU divide by zero → ONES (0xFFFFFFFF).
  - REM/REMU divide by zero → RS1.
  - DIV overflow → MIN (0x80000000).
  - REM overflow → ZERO.
- mux_out is ZERO in all states except DONE.

## Timing
- Request accepted at cycle T, meaning the edge ending T with valid high in IDLE.
- busy is high from T+1 through the ready cycle inclusive, and low in IDLE.
- MUL: mul_en at T+1..T+MUL_CYCLES; ready/wr at T+MUL_CYCLES+1.
- DIV: div_step at T+1..T+DIV_CYCLES; ready/wr at T+DIV_CYCLES+1.
- Special cases: ready/wr at T+1; no div_step is issued.
- valid while busy is ignored and nothing is queued. The earliest next acceptance is the cycle after ready.
- Reset value of every output is 0, with mux_out = ZERO. Reset puts the state in IDLE and clears the counter.
- Reset mid-operation aborts: IDLE on the next cycle, no ready/wr pulse, and the latched flags are cleared.

## Structure
- Package m_unit_pkg holds:
  - MUX_OUT_* encodings: ZERO=0, DIV_REM=1, DIV_REM_NEG=2, MULT_LOWER=3, MULT_UPPER=4, RS1=5, ONES=6, MIN=7.
  - MUX_OUT_LENGTH.
  - The state enum.
  - The funct3 op enum.
  - OPCODE_OP and FUNCT7_MULDIV constants.
- Sub-module m_unit_decode: purely combinational. It maps instruction to is_m, is_div, op, and the signedness flags. The FSM and counter stay in m_unit_controller.

## Test plan
- MUL: instruction 0x02B50533 with valid at T → load at T, mul_en at T+1..T+2, ready=wr=1 at T+3 with mux_out=MULT_LOWER, busy low at T+4.
- Signed DIV: 0x02B54533 with rs1_msb=1, rs2_msb=0 → 32 div_step pulses at T+1..T+32, ready at T+33 with mux_out=DIV_REM_NEG.
- DIVU by zero: 0x02B55533 with rs2_zero=1 → ready at T+1, mux_out=ONES, zero div_step. REMU by zero (0x02B57533) → mux_out=RS1.
- REM overflow: 0x02B56533 with div_ovf=1 → ready at T+1, mux_out=ZERO. DIV overflow (0x02B54533) → mux_out=MIN.
- Pulse valid with MULHU (0x02B53533) at T+5 during a DIV → ignored, only one ready at T+33. Assert reset at T+10 → IDLE at T+11, no ready.
- Non-M instruction ADD 0x00B50533 with valid → load=0, busy stays 0, no ready over 40 cycles.

Source files
------------

// File: rtl/m_unit_pkg.sv
// Shared types and constants for the RISC-V M-extension sequencing controller.
// Also holds the DONE-state result selection as a helper function.
package m_unit_pkg;

  localparam int MUX_OUT_LENGTH = 3;

  localparam logic [MUX_OUT_LENGTH-1:0] MUX_OUT_ZERO        = 3'd0;
  localparam logic [MUX_OUT_LENGTH-1:0] MUX_OUT_DIV_REM     = 3'd1;
  localparam logic [MUX_OUT_LENGTH-1:0] MUX_OUT_DIV_REM_NEG = 3'd2;
  localparam logic [MUX_OUT_LENGTH-1:0] MUX_OUT_MULT_LOWER  = 3'd3;
  localparam logic [MUX_OUT_LENGTH-1:0] MUX_OUT_MULT_UPPER  = 3'd4;
  localparam logic [MUX_OUT_LENGTH-1:0] MUX_OUT_RS1         = 3'd5;
  localparam logic [MUX_OUT_LENGTH-1:0] MUX_OUT_ONES        = 3'd6;
  localparam logic [MUX_OUT_LENGTH-1:0] MUX_OUT_MIN         = 3'd7;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  // Divide-by-zero outranks overflow; overflow flags are only ever set for signed ops.
  function automatic logic [MUX_OUT_LENGTH-1:0] sel_result(
    input op_e  op,
    input logic div_zero,
    input logic div_ovf,
    input logic sign1,
    input logic sign2
  );
    logic [MUX_OUT_LENGTH-1:0] sel;
    sel = MUX_OUT_ZERO;
    case (op)
      OP_MUL:                     sel = MUX_OUT_MULT_LOWER;
      OP_MULH, OP_MULHSU, OP_MULHU: sel = MUX_OUT_MULT_UPPER;
      OP_DIV: begin
        if (div_zero)           sel = MUX_OUT_ONES;
        else if (div_ovf)       sel = MUX_OUT_MIN;
        else if (sign1 ^ sign2) sel = MUX_OUT_DIV_REM_NEG;
        else                    sel = MUX_OUT_DIV_REM;
      end
      OP_DIVU: begin
        if (div_zero) sel = MUX_OUT_ONES;
        else          sel = MUX_OUT_DIV_REM;
      end
      OP_REM: begin
        if (div_zero)     sel = MUX_OUT_RS1;
        else if (div_ovf) sel = MUX_OUT_ZERO;
        else if (sign1)   sel = MUX_OUT_DIV_REM_NEG;
        else              sel = MUX_OUT_DIV_REM;
      end
      OP_REMU: begin
        if (div_zero) sel = MUX_OUT_RS1;
        else          sel = MUX_OUT_DIV_REM;
      end
      default: sel = MUX_OUT_ZERO;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/m_unit_decode.sv
// Combinational decoder: recognises OP-format M instructions and classifies
// the funct3 operation and its operand signedness.
module m_unit_decode
  import m_unit_pkg::*;
(
  input  logic [31:0] instruction,
  output logic        is_m,
  output logic        is_div,
  output op_e         op,
  output logic        signed_a,
  output logic        signed_b,
  output logic        div_signed
);

  logic unused_fields_s;

  // Register specifiers are irrelevant to sequencing.
  assign unused_fields_s = ^{instruction[24:15], instruction[11:7]};

  // Field decode and operation classification.
  always_comb begin
    op         = op_e'(instruction[14:12]);
    is_m       = (instruction[6:0] == OPCODE_OP) && (instruction[31:25] == FUNCT7_MULDIV);
    is_div     = is_m & instruction[14];
    signed_a   = is_m & ((op == OP_MULH) | (op == OP_MULHSU));
    signed_b   = is_m & (op == OP_MULH);
    div_signed = is_m & ((op == OP_DIV) | (op == OP_REM));
  end

endmodule

// File: rtl/m_unit_controller.sv
// Sequencing FSM for the M-extension unit: accepts a request, times the
// multiply/divide phases, and selects the result in DONE.
module m_unit_controller
  import m_unit_pkg::*;
#(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      valid,
  input  logic [31:0]               instruction,
  input  logic                      rs1_msb,
  input  logic                      rs2_msb,
  input  logic                      rs2_zero,
  input  logic                      div_ovf,
  output logic                      load,
  output logic                      mul_en,
  output logic                      mul_signed_a,
  output logic                      mul_signed_b,
  output logic                      div_step,
  output logic [MUX_OUT_LENGTH-1:0] mux_out,
  output logic                      busy,
  output logic                      ready,
  output logic                      wr
);

  localparam int CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - 1);

  state_e           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;

  logic is_m_s, is_div_s, signed_a_s, signed_b_s, div_signed_s;
  op_e  op_s;
  logic accept_s, special_s;

  op_e  op_r;
  logic zero_r, ovf_r, sign1_r, sign2_r, sa_r, sb_r;

  m_unit_decode u_decode (
    .instruction (instruction),
    .is_m        (is_m_s),
    .is_div      (is_div_s),
    .op          (op_s),
    .signed_a    (signed_a_s),
    .signed_b    (signed_b_s),
    .div_signed  (div_signed_s)
  );

  // Acceptance and the divide corner cases that skip the iterative phase.
  assign accept_s  = valid & is_m_s & (state_r == ST_IDLE);
  assign special_s = is_div_s & (rs2_zero | (div_ovf & div_signed_s));
  assign load      = accept_s;

  // State and cycle counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = '0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (!is_div_s)      state_s = ST_MUL;
          else if (special_s) state_s = ST_DONE;
          else                state_s = ST_DIV;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (cnt_r == MUL_LAST) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_MUL;
          cnt_s   = cnt_r + CNT_W'(1);
        end
      end
      ST_DIV: begin
        if (cnt_r == DIV_LAST) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_DIV;
          cnt_s   = cnt_r + CNT_W'(1);
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Operation and operand flags captured on acceptance; overflow only matters for signed divides.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_r    <= OP_MUL;
      zero_r  <= 1'b0;
      ovf_r   <= 1'b0;
      sign1_r <= 1'b0;
      sign2_r <= 1'b0;
      sa_r    <= 1'b0;
      sb_r    <= 1'b0;
    end else if (accept_s) begin
      op_r    <= op_s;
      zero_r  <= rs2_zero & is_div_s;
      ovf_r   <= div_ovf & div_signed_s;
      sign1_r <= rs1_msb & div_signed_s;
      sign2_r <= rs2_msb & div_signed_s;
      sa_r    <= signed_a_s;
      sb_r    <= signed_b_s;
    end else begin
      op_r    <= op_r;
      zero_r  <= zero_r;
      ovf_r   <= ovf_r;
      sign1_r <= sign1_r;
      sign2_r <= sign2_r;
      sa_r    <= sa_r;
      sb_r    <= sb_r;
    end
  end

  // Datapath strobes and handshake derived from the registered state.
  always_comb begin
    mul_en       = (state_r == ST_MUL);
    mul_signed_a = mul_en & sa_r;
    mul_signed_b = mul_en & sb_r;
    div_step     = (state_r == ST_DIV);
    busy         = (state_r != ST_IDLE);
    ready        = (state_r == ST_DONE);
    wr           = ready;
    if (state_r == ST_DONE) begin
      mux_out = sel_result(op_r, zero_r, ovf_r, sign1_r, sign2_r);
    end else begin
      mux_out = MUX_OUT_ZERO;
    end
  end

endmodule

// File: tb/tb_m_unit_controller.sv
// Directed self-checking bench for m_unit_controller with hand-computed
// cycle positions and result-select codes.
module tb_m_unit_controller;

  logic        clk;
  logic        reset;
  logic        valid;
  logic [31:0] instruction;
  logic        rs1_msb, rs2_msb, rs2_zero, div_ovf;
  logic        load, mul_en, mul_signed_a, mul_signed_b, div_step;
  logic [2:0]  mux_out;
  logic        busy, ready, wr;

  int checks = 0;
  int errors = 0;

  m_unit_controller #(.MUL_CYCLES(2), .DIV_CYCLES(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .valid        (valid),
    .instruction  (instruction),
    .rs1_msb      (rs1_msb),
    .rs2_msb      (rs2_msb),
    .rs2_zero     (rs2_zero),
    .div_ovf      (div_ovf),
    .load         (load),
    .mul_en       (mul_en),
    .mul_signed_a (mul_signed_a),
    .mul_signed_b (mul_signed_b),
    .div_step     (div_step),
    .mux_out      (mux_out),
    .busy         (busy),
    .ready        (ready),
    .wr           (wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request in IDLE for one cycle (cycle T); returns sampling at T+1.
  task automatic accept(input logic [31:0] instr, input logic s1, input logic s2,
                        input logic z, input logic ovf);
    instruction = instr;
    rs1_msb     = s1;
    rs2_msb     = s2;
    rs2_zero    = z;
    div_ovf     = ovf;
    valid       = 1'b1;
    #1;
    check("load_at_T", 32'(load), 32'd1);
    check("busy_at_T", 32'(busy), 32'd0);
    tick();
    valid = 1'b0;
  endtask

  // Observe cycles T+1..T+budget, tallying strobes and the first ready.
  task automatic run(input int budget, output int first_ready, output int readies,
                     output int mux_at_ready, output int steps, output int first_step,
                     output int muls, output int busys);
    first_ready = 0; readies = 0; mux_at_ready = -1;
    steps = 0; first_step = 0; muls = 0; busys = 0;
    for (int c = 1; c <= budget; c++) begin
      if (div_step) begin
        steps++;
        if (first_step == 0) first_step = c;
      end
      if (mul_en) muls++;
      if (busy) busys++;
      if (ready) begin
        readies++;
        check("wr_with_ready", 32'(wr), 32'd1);
        if (first_ready == 0) begin
          first_ready  = c;
          mux_at_ready = int'(mux_out);
        end
      end
      tick();
    end
  endtask

  int fr, nr, mx, st, fs, nm, nb;

  initial begin
    reset = 1'b1; valid = 1'b0; instruction = 32'd0;
    rs1_msb = 1'b0; rs2_msb = 1'b0; rs2_zero = 1'b0; div_ovf = 1'b0;
    tick(); tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_wr", 32'(wr), 32'd0);
    check("rst_mul_en", 32'(mul_en), 32'd0);
    check("rst_div_step", 32'(div_step), 32'd0);
    check("rst_mux", 32'(mux_out), 32'd0);
    reset = 1'b0;
    tick();

    // MUL
    accept(32'h02B50533, 1'b0, 1'b0, 1'b0, 1'b0);
    check("mul_en_T1", 32'(mul_en), 32'd1);
    check("mul_sa_T1", 32'(mul_signed_a), 32'd0);
    run(6, fr, nr, mx, st, fs, nm, nb);
    check("mul_ready_cyc", 32'(fr), 32'd3);
    check("mul_readies", 32'(nr), 32'd1);
    check("mul_mux", 32'(mx), 32'd3);
    check("mul_en_cycles", 32'(nm), 32'd2);
    check("mul_busy_cycles", 32'(nb), 32'd3);

    // MULH: both signed, upper half
    accept(32'h02B51533, 1'b1, 1'b1, 1'b0, 1'b0);
    check("mulh_sa", 32'(mul_signed_a), 32'd1);
    check("mulh_sb", 32'(mul_signed_b), 32'd1);
    run(5, fr, nr, mx, st, fs, nm, nb);
    check("mulh_mux", 32'(mx), 32'd4);

    // MULHSU: only rs1 signed
    accept(32'h02B52533, 1'b1, 1'b1, 1'b0, 1'b0);
    check("mulhsu_sa", 32'(mul_signed_a), 32'd1);
    check("mulhsu_sb", 32'(mul_signed_b), 32'd0);
    run(5, fr, nr, mx, st, fs, nm, nb);
    check("mulhsu_mux", 32'(mx), 32'd4);

    // Signed DIV, signs differ
    accept(32'h02B54533, 1'b1, 1'b0, 1'b0, 1'b0);
    run(40, fr, nr, mx, st, fs, nm, nb);
    check("div_steps", 32'(st), 32'd32);
    check("div_first_step", 32'(fs), 32'd1);
    check("div_ready_cyc", 32'(fr), 32'd33);
    check("div_readies", 32'(nr), 32'd1);
    check("div_mux", 32'(mx), 32'd2);
    check("div_busy_cycles", 32'(nb), 32'd33);

    // REM with negative dividend
    accept(32'h02B56533, 1'b1, 1'b1, 1'b0, 1'b0);
    run(40, fr, nr, mx, st, fs, nm, nb);
    check("rem_neg_ready_cyc", 32'(fr), 32'd33);
    check("rem_neg_mux", 32'(mx), 32'd2);

    // DIVU ignores div_ovf: full divide, plain quotient
    accept(32'h02B55533, 1'b1, 1'b1, 1'b0, 1'b1);
    run(40, fr, nr, mx, st, fs, nm, nb);
    check("divu_ovf_ready_cyc", 32'(fr), 32'd33);
    check("divu_ovf_mux", 32'(mx), 32'd1);

    // DIVU by zero
    accept(32'h02B55533, 1'b0, 1'b0, 1'b1, 1'b0);
    run(4, fr, nr, mx, st, fs, nm, nb);
    check("divu_z_ready_cyc", 32'(fr), 32'd1);
    check("divu_z_mux", 32'(mx), 32'd6);
    check("divu_z_steps", 32'(st), 32'd0);
    check("divu_z_busy_cycles", 32'(nb), 32'd1);

    // REMU by zero
    accept(32'h02B57533, 1'b0, 1'b0, 1'b1, 1'b0);
    run(4, fr, nr, mx, st, fs, nm, nb);
    check("remu_z_ready_cyc", 32'(fr), 32'd1);
    check("remu_z_mux", 32'(mx), 32'd5);

    // REM overflow
    accept(32'h02B56533, 1'b1, 1'b1, 1'b0, 1'b1);
    run(4, fr, nr, mx, st, fs, nm, nb);
    check("rem_ovf_ready_cyc", 32'(fr), 32'd1);
    check("rem_ovf_mux", 32'(mx), 32'd0);
    check("rem_ovf_steps", 32'(st), 32'd0);

    // DIV overflow
    accept(32'h02B54533, 1'b1, 1'b1, 1'b0, 1'b1);
    run(4, fr, nr, mx, st, fs, nm, nb);
    check("div_ovf_ready_cyc", 32'(fr), 32'd1);
    check("div_ovf_mux", 32'(mx), 32'd7);

    // MULHU pulsed at T+5 during a DIV must be ignored
    accept(32'h02B54533, 1'b1, 1'b0, 1'b0, 1'b0);
    nr = 0; fr = 0; mx = -1;
    for (int c = 1; c <= 40; c++) begin
      if (ready) begin
        nr++;
        if (fr == 0) begin fr = c; mx = int'(mux_out); end
      end
      if (c == 5) begin
        instruction = 32'h02B53533;
        valid = 1'b1;
        #1;
        check("ign_load", 32'(load), 32'd0);
      end else if (c == 6) begin
        valid = 1'b0;
      end
      tick();
    end
    check("ign_readies", 32'(nr), 32'd1);
    check("ign_ready_cyc", 32'(fr), 32'd33);
    check("ign_mux", 32'(mx), 32'd2);

    // Reset at T+10 aborts a DIV
    accept(32'h02B54533, 1'b1, 1'b0, 1'b0, 1'b0);
    nr = 0;
    for (int c = 1; c <= 40; c++) begin
      if (ready) nr++;
      if (c == 10) begin
        reset = 1'b1;
      end else if (c == 11) begin
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_div_step", 32'(div_step), 32'd0);
        reset = 1'b0;
      end
      tick();
    end
    check("abort_readies", 32'(nr), 32'd0);

    // Non-M ADD held valid for 40 cycles
    instruction = 32'h00B50533;
    valid = 1'b1;
    nr = 0; nb = 0; nm = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (load) nm++;
      if (busy) nb++;
      if (ready) nr++;
      tick();
    end
    valid = 1'b0;
    check("add_load", 32'(nm), 32'd0);
    check("add_busy", 32'(nb), 32'd0);
    check("add_ready", 32'(nr), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
